// File: rtl/pass_engine.sv
// Pass engine: steps a neuron index per requested training pass,
// handshaking each index with the MAC datapath and flagging completion.
module pass_engine #(
  parameter int N0     = 4,
  parameter int N1     = 2,
  parameter int IDX_W  = 3,
  parameter int ERR_W  = 8,
  parameter int THRESH = 8,
  parameter int MAX_EP = 4,
  parameter int EP_W   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             f0_pass_i,
  input  logic             f1_pass_i,
  input  logic             b_pass_i,
  input  logic             step_ack_i,
  input  logic [ERR_W-1:0] err_i,
  output logic             step_req_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [1:0]       layer_o,
  output logic             busy_o,
  output logic             f0_end_o,
  output logic             f1_end_o,
  output logic             b_end_o,
  output logic             end_check_o,
  output logic             proto_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_HOLD
  } state_t;

  localparam logic [1:0] L_NONE = 2'b00;
  localparam logic [1:0] L_F0   = 2'b01;
  localparam logic [1:0] L_F1   = 2'b10;
  localparam logic [1:0] L_B    = 2'b11;

  localparam logic [IDX_W-1:0] LAST0 = IDX_W'(N0 - 1);
  localparam logic [IDX_W-1:0] LAST1 = IDX_W'(N1 - 1);
  localparam logic [ERR_W-1:0] TH    = ERR_W'(THRESH);
  localparam logic [EP_W-1:0]  EP_LAST = EP_W'(MAX_EP - 1);

  state_t           state;
  logic [EP_W-1:0]  epoch;
  logic             act_en;
  logic [IDX_W-1:0] last_idx;
  logic [1:0]       n_en;
  logic [1:0]       sel_layer;

  always_comb begin
    act_en = 1'b0;
    unique case (layer_o)
      L_F0:    act_en = f0_pass_i;
      L_F1:    act_en = f1_pass_i;
      L_B:     act_en = b_pass_i;
      default: act_en = 1'b0;
    endcase
    last_idx = (layer_o == L_F0) ? LAST0 : LAST1;
    n_en = {1'b0, f0_pass_i} + {1'b0, f1_pass_i} + {1'b0, b_pass_i};
    if (f0_pass_i)      sel_layer = L_F0;
    else if (f1_pass_i) sel_layer = L_F1;
    else                sel_layer = L_B;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      epoch       <= '0;
      step_req_o  <= 1'b0;
      idx_o       <= '0;
      layer_o     <= L_NONE;
      busy_o      <= 1'b0;
      f0_end_o    <= 1'b0;
      f1_end_o    <= 1'b0;
      b_end_o     <= 1'b0;
      end_check_o <= 1'b0;
      proto_err_o <= 1'b0;
    end else if (en_i) begin
      f0_end_o    <= 1'b0;
      f1_end_o    <= 1'b0;
      b_end_o     <= 1'b0;
      end_check_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (n_en == 2'd1) begin
            state      <= S_REQ;
            step_req_o <= 1'b1;
            busy_o     <= 1'b1;
            idx_o      <= '0;
            layer_o    <= sel_layer;
            if (f0_pass_i) epoch <= '0;
          end else if (n_en > 2'd1) begin
            proto_err_o <= 1'b1;
          end
        end
        S_REQ, S_DONE: begin
          if (!act_en) begin
            // abort: enable withdrawn mid-pass
            state      <= S_IDLE;
            step_req_o <= 1'b0;
            busy_o     <= 1'b0;
            idx_o      <= '0;
            layer_o    <= L_NONE;
          end else if (state == S_REQ) begin
            if (step_ack_i) begin
              if (idx_o == last_idx) begin
                state      <= S_DONE;
                step_req_o <= 1'b0;
              end else begin
                idx_o <= idx_o + 1'b1;
              end
            end
          end else if (layer_o == L_F0 &&
                       err_i >= TH && epoch != EP_LAST) begin
            f0_end_o   <= 1'b1;
            epoch      <= epoch + 1'b1;
            idx_o      <= '0;
            step_req_o <= 1'b1;
            state      <= S_REQ;
          end else begin
            end_check_o <= (layer_o == L_F0);
            f1_end_o    <= (layer_o == L_F1);
            b_end_o     <= (layer_o == L_B);
            idx_o       <= '0;
            busy_o      <= 1'b0;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!act_en) begin
            state   <= S_IDLE;
            layer_o <= L_NONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pass_engine.sv
// Bench for pass_engine: scenario tasks with randomized acks and
// error values checked against handshake/epoch arithmetic.
module tb_pass_engine;
  localparam int N0 = 4, N1 = 2, IDX_W = 3, ERR_W = 8;
  localparam int THRESH = 8, MAX_EP = 4, EP_W = 3;

  logic clk_i = 1'b0;
  logic rst_i, en_i, f0_pass_i, f1_pass_i, b_pass_i, step_ack_i;
  logic [ERR_W-1:0] err_i;
  logic step_req_o, busy_o, f0_end_o, f1_end_o, b_end_o;
  logic end_check_o, proto_err_o;
  logic [IDX_W-1:0] idx_o;
  logic [1:0] layer_o;

  int total = 0;
  int bad = 0;

  pass_engine #(
    .N0(N0), .N1(N1), .IDX_W(IDX_W), .ERR_W(ERR_W),
    .THRESH(THRESH), .MAX_EP(MAX_EP), .EP_W(EP_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .f0_pass_i(f0_pass_i), .f1_pass_i(f1_pass_i),
    .b_pass_i(b_pass_i), .step_ack_i(step_ack_i),
    .err_i(err_i), .step_req_o(step_req_o), .idx_o(idx_o),
    .layer_o(layer_o), .busy_o(busy_o), .f0_end_o(f0_end_o),
    .f1_end_o(f1_end_o), .b_end_o(b_end_o),
    .end_check_o(end_check_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [11:0] outs();
    return {step_req_o, idx_o, layer_o, busy_o, f0_end_o,
            f1_end_o, b_end_o, end_check_o, proto_err_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_pass(input int kind, input logic v);
    case (kind)
      1: f0_pass_i = v;
      2: f1_pass_i = v;
      default: b_pass_i = v;
    endcase
  endtask

  task automatic test_reset();
    rst_i = 1'b0; en_i = 1'b1; step_ack_i = 1'b0; err_i = '0;
    f0_pass_i = 1'b0; f1_pass_i = 1'b0; b_pass_i = 1'b0;
    #12;
    total++;
    if (outs() !== 12'h000) begin
      bad++;
      $display("FAIL reset_outs got=%h want=000", outs());
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    total++;
    if (outs() !== 12'h000) begin
      bad++;
      $display("FAIL idle_outs got=%h want=000", outs());
    end
  endtask

  // kind: 1=f0 2=f1 3=b; err_mode: 0 zero, 1 large, 2 random
  task automatic run_pass(input string name, input int kind,
                          input int err_mode, input int stall);
    int n, epochs, hs, hs_ep, ep, f0e, ecn, f1e, be, stall_left;
    int end_edge, want_f0e;
    int errs[MAX_EP];
    bit prev_req, prev_ack, done;
    logic [1:0] lay;
    lay = 2'(kind);
    n = (kind == 1) ? N0 : N1;
    for (int i = 0; i < MAX_EP; i++)
      errs[i] = (err_mode == 0) ? 0 :
                (err_mode == 1) ? 200 : int'($urandom_range(0, 20));
    epochs = 1;
    if (kind == 1) begin
      epochs = MAX_EP;
      for (int i = 0; i < MAX_EP; i++)
        if (errs[i] < THRESH) begin
          epochs = i + 1;
          break;
        end
    end
    hs = 0; hs_ep = 0; ep = 0; f0e = 0; ecn = 0; f1e = 0; be = 0;
    done = 0; end_edge = -1;
    err_i = ERR_W'(errs[0]);
    stall_left = stall;
    step_ack_i = (stall == 0);
    set_pass(kind, 1'b1);
    for (int c = 0; c < 300 && !done; c++) begin
      prev_req = step_req_o;
      prev_ack = step_ack_i;
      tick();
      if (prev_req && prev_ack) begin
        hs++;
        hs_ep++;
      end
      if (f0_end_o) begin
        f0e++;
        hs_ep = 0;
        ep++;
        if (ep < MAX_EP) err_i = ERR_W'(errs[ep]);
      end
      if (end_check_o) ecn++;
      if (f1_end_o) f1e++;
      if (b_end_o) be++;
      if (step_req_o) begin
        total++;
        if ({layer_o, idx_o} !== {lay, IDX_W'(hs_ep)}) begin
          bad++;
          $display("FAIL %s_idx got=%h want=%h", name,
                   {layer_o, idx_o}, {lay, IDX_W'(hs_ep)});
        end
      end
      if ((kind == 1 && end_check_o) || (kind == 2 && f1_end_o) ||
          (kind == 3 && be > 0)) begin
        done = 1;
        end_edge = c;
      end
      if (prev_req && prev_ack) stall_left = stall;
      else if (stall_left > 0) stall_left--;
      step_ack_i = (stall_left == 0);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout got=no_end want=end_pulse", name);
    end
    total++;
    if (hs != n * epochs) begin
      bad++;
      $display("FAIL %s_handshakes got=%0d want=%0d", name, hs, n * epochs);
    end
    want_f0e = (kind == 1) ? epochs - 1 : 0;
    total++;
    if ({f0e, ecn, f1e, be} !== {want_f0e, int'(kind == 1),
                                 int'(kind == 2), int'(kind == 3)}) begin
      bad++;
      $display("FAIL %s_pulses got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
               name, f0e, ecn, f1e, be, want_f0e, int'(kind == 1),
               int'(kind == 2), int'(kind == 3));
    end
    if (stall == 0) begin
      total++;
      if (end_edge != epochs * (n + 1)) begin
        bad++;
        $display("FAIL %s_latency got=%0d want=%0d", name, end_edge,
                 epochs * (n + 1));
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outs() !== {1'b0, 3'd0, lay, 6'd0}) begin
        bad++;
        $display("FAIL %s_hold got=%h want=%h", name, outs(),
                 {1'b0, 3'd0, lay, 6'd0});
      end
    end
    set_pass(kind, 1'b0);
    tick();
    total++;
    if (outs() !== 12'h000) begin
      bad++;
      $display("FAIL %s_release got=%h want=000", name, outs());
    end
  endtask

  task automatic test_random();
    int k, s;
    for (int i = 0; i < 6; i++) begin
      k = int'($urandom_range(1, 3));
      s = int'($urandom_range(0, 2));
      run_pass("rand", k, 2, s);
    end
  endtask

  task automatic test_abort();
    step_ack_i = 1'b1; err_i = '0;
    f0_pass_i = 1'b1;
    tick(); tick(); tick();
    total++;
    if ({step_req_o, idx_o} !== 4'b1010) begin
      bad++;
      $display("FAIL abort_pre got=%b want=1010", {step_req_o, idx_o});
    end
    f0_pass_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (outs() !== 12'h000) begin
        bad++;
        $display("FAIL abort_idle got=%h want=000", outs());
      end
    end
    f0_pass_i = 1'b1;
    tick(); tick();
    en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({step_req_o, idx_o, layer_o} !== 6'b100101) begin
        bad++;
        $display("FAIL freeze got=%b want=100101",
                 {step_req_o, idx_o, layer_o});
      end
    end
    en_i = 1'b1;
    tick();
    total++;
    if ({step_req_o, idx_o} !== 4'b1010) begin
      bad++;
      $display("FAIL unfreeze got=%b want=1010", {step_req_o, idx_o});
    end
    f0_pass_i = 1'b0;
    tick();
    total++;
    if (outs() !== 12'h000) begin
      bad++;
      $display("FAIL abort2 got=%h want=000", outs());
    end
  endtask

  task automatic test_proto();
    f0_pass_i = 1'b1; b_pass_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outs() !== 12'h001) begin
        bad++;
        $display("FAIL proto_set got=%h want=001", outs());
      end
    end
    f0_pass_i = 1'b0; b_pass_i = 1'b0;
    tick();
    total++;
    if (outs() !== 12'h001) begin
      bad++;
      $display("FAIL proto_sticky got=%h want=001", outs());
    end
  endtask

  task automatic test_midreset();
    step_ack_i = 1'b1;
    f1_pass_i = 1'b1;
    tick(); tick(); tick();
    total++;
    if ({step_req_o, busy_o, proto_err_o} !== 3'b011) begin
      bad++;
      $display("FAIL done_state got=%b want=011",
               {step_req_o, busy_o, proto_err_o});
    end
    #2 rst_i = 1'b0;
    #1;
    total++;
    if (outs() !== 12'h000) begin
      bad++;
      $display("FAIL async_reset got=%h want=000", outs());
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    total++;
    if (outs() !== {1'b1, 3'd0, 2'b10, 1'b1, 5'd0}) begin
      bad++;
      $display("FAIL restart got=%h want=%h", outs(),
               {1'b1, 3'd0, 2'b10, 1'b1, 5'd0});
    end
    f1_pass_i = 1'b0;
    tick();
    total++;
    if (outs() !== 12'h000) begin
      bad++;
      $display("FAIL restart_abort got=%h want=000", outs());
    end
  endtask

  initial begin
    test_reset();
    run_pass("f0_conv", 1, 0, 0);
    run_pass("f0_div", 1, 1, 0);
    run_pass("f1_stall", 2, 0, 2);
    run_pass("b_stall", 3, 0, 2);
    test_random();
    test_abort();
    test_proto();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
